// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the two requesting masters, the shared memory port and mem_bus_arbiter.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              i_m0_req;
    logic              i_m0_wr;
    logic [ADDR_W-1:0] i_m0_addr;
    logic [DATA_W-1:0] i_m0_wdata;
    logic              o_m0_ack;
    logic [DATA_W-1:0] o_m0_rdata;

    logic              i_m1_req;
    logic              i_m1_wr;
    logic [ADDR_W-1:0] i_m1_addr;
    logic [DATA_W-1:0] i_m1_wdata;
    logic              o_m1_ack;
    logic [DATA_W-1:0] o_m1_rdata;

    logic              o_mem_rd;
    logic              o_mem_wr;
    logic [ADDR_W-1:0] o_mem_address;
    logic [DATA_W-1:0] o_mem_data;
    logic [DATA_W-1:0] i_mem_data;

    logic              o_owner;
    logic              o_busy;

    modport slave (
        input  i_m0_req, i_m0_wr, i_m0_addr, i_m0_wdata,
        input  i_m1_req, i_m1_wr, i_m1_addr, i_m1_wdata,
        input  i_mem_data,
        output o_m0_ack, o_m0_rdata, o_m1_ack, o_m1_rdata,
        output o_mem_rd, o_mem_wr, o_mem_address, o_mem_data,
        output o_owner, o_busy
    );

    modport master (
        output i_m0_req, i_m0_wr, i_m0_addr, i_m0_wdata,
        output i_m1_req, i_m1_wr, i_m1_addr, i_m1_wdata,
        output i_mem_data,
        input  o_m0_ack, o_m0_rdata, o_m1_ack, o_m1_rdata,
        input  o_mem_rd, o_mem_wr, o_mem_address, o_mem_data,
        input  o_owner, o_busy
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter/sequencer for a shared single-port memory with fixed read latency.
// Define MEM_ARB_FIXED_PRIO_EN to make master 0 win every tie (default: round-robin).
module mem_bus_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int RD_LATENCY = 1    // legal range 1..4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    mem_bus_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RWAIT  = 2'd2;
    localparam logic [1:0] ACK    = 2'd3;

    localparam logic [2:0] RWAIT_LOAD = 3'(RD_LATENCY - 1);

    logic [1:0]        state;
    logic              last_winner;
    logic              xfer_wr;
    logic [2:0]        rwait_cnt;

    logic              any_req;
    logic              pick;
    logic              pick_wr;
    logic [ADDR_W-1:0] pick_addr;
    logic [DATA_W-1:0] pick_wdata;

    function automatic logic pick_winner(input logic r0, input logic r1, input logic lw);
`ifdef MEM_ARB_FIXED_PRIO_EN
        pick_winner = ~r0;
`else
        // A lone requester wins outright; on a tie the previous loser goes next.
        pick_winner = (r0 & r1) ? ~lw : r1;
`endif
    endfunction

    always_comb begin
        any_req    = bus.i_m0_req | bus.i_m1_req;
        pick       = pick_winner(bus.i_m0_req, bus.i_m1_req, last_winner);
        pick_wr    = pick ? bus.i_m1_wr    : bus.i_m0_wr;
        pick_addr  = pick ? bus.i_m1_addr  : bus.i_m0_addr;
        pick_wdata = pick ? bus.i_m1_wdata : bus.i_m0_wdata;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state             <= IDLE;
            last_winner       <= 1'b1;
            xfer_wr           <= 1'b0;
            rwait_cnt         <= '0;
            bus.o_mem_rd      <= 1'b0;
            bus.o_mem_wr      <= 1'b0;
            bus.o_mem_address <= '0;
            bus.o_mem_data    <= '0;
            bus.o_m0_ack      <= 1'b0;
            bus.o_m1_ack      <= 1'b0;
            bus.o_m0_rdata    <= '0;
            bus.o_m1_rdata    <= '0;
            bus.o_owner       <= 1'b0;
            bus.o_busy        <= 1'b0;
        end else begin
            // Strobes and acks are single-cycle pulses unless re-asserted below.
            bus.o_mem_rd <= 1'b0;
            bus.o_mem_wr <= 1'b0;
            bus.o_m0_ack <= 1'b0;
            bus.o_m1_ack <= 1'b0;

            case (state)
                IDLE: begin
                    if (any_req) begin
                        state             <= ACCESS;
                        bus.o_owner       <= pick;
                        xfer_wr           <= pick_wr;
                        bus.o_mem_wr      <= pick_wr;
                        bus.o_mem_rd      <= ~pick_wr;
                        bus.o_mem_address <= pick_addr;
                        bus.o_mem_data    <= pick_wdata;
                        bus.o_busy        <= 1'b1;
                    end
                end

                ACCESS: begin
                    if (xfer_wr) begin
                        state        <= ACK;
                        bus.o_m0_ack <= ~bus.o_owner;
                        bus.o_m1_ack <= bus.o_owner;
                    end else begin
                        state     <= RWAIT;
                        rwait_cnt <= RWAIT_LOAD;
                    end
                end

                RWAIT: begin
                    // Counter hits zero in the cycle the memory presents the read word.
                    if (rwait_cnt == 3'd0) begin
                        state        <= ACK;
                        bus.o_m0_ack <= ~bus.o_owner;
                        bus.o_m1_ack <= bus.o_owner;
                        if (bus.o_owner) begin
                            bus.o_m1_rdata <= bus.i_mem_data;
                        end else begin
                            bus.o_m0_rdata <= bus.i_mem_data;
                        end
                    end else begin
                        rwait_cnt <= rwait_cnt - 3'd1;
                    end
                end

                ACK: begin
                    state       <= IDLE;
                    last_winner <= bus.o_owner;
                    bus.o_busy  <= 1'b0;
                end

                default: begin
                    state      <= IDLE;
                    bus.o_busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: transaction-level timeline model, a memory
// stand-in with fixed read latency, directed scenarios with literal expectations, random traffic.
module tb_mem_bus_arbiter;
    localparam int RD_LAT = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_bus_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus();

    mem_bus_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LATENCY(RD_LAT)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    // master stimulus
    logic        req   [2];
    logic        wr    [2];
    logic [15:0] addr  [2];
    logic [15:0] wdata [2];

    assign bus.i_m0_req   = req[0];
    assign bus.i_m0_wr    = wr[0];
    assign bus.i_m0_addr  = addr[0];
    assign bus.i_m0_wdata = wdata[0];
    assign bus.i_m1_req   = req[1];
    assign bus.i_m1_wr    = wr[1];
    assign bus.i_m1_addr  = addr[1];
    assign bus.i_m1_wdata = wdata[1];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;

    // memory stand-in
    logic [15:0] mem [0:1023];
    int          pend_due[$];
    logic [15:0] pend_addr[$];

    // reference model: one transaction described by its grant and ack cycles
    logic [15:0] ref_mem [0:1023];
    bit          act;
    int          cur_g, cur_a;
    bit          cur_m, cur_wr;
    logic [15:0] cur_addr, cur_wdata;
    int          free_at;
    bit          lw;
    bit          e_owner;
    logic [15:0] e_addr, e_data;
    logic [15:0] e_rdata [2];
    bit          x_rd, x_wr, x_busy;
    bit          x_ack [2];

    task automatic chk1(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, got, want);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
        end
    endtask

    // Inputs of cycle cyc, as seen by the edge that closes it.
    task automatic model_sample();
        bit win;
        if (rst) begin
            act     = 1'b0;
            lw      = 1'b1;
            free_at = cyc + 1;
            e_owner = 1'b0;
            e_addr  = '0;
            e_data  = '0;
            e_rdata[0] = '0;
            e_rdata[1] = '0;
        end else if (cyc == free_at) begin
            if (req[0] || req[1]) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
                win = req[0] ? 1'b0 : 1'b1;
`else
                if (req[0] && req[1]) win = ~lw;
                else                  win = req[1];
`endif
                act       = 1'b1;
                cur_m     = win;
                cur_wr    = wr[win];
                cur_addr  = addr[win];
                cur_wdata = wdata[win];
                cur_g     = cyc;
                cur_a     = cyc + 2 + (cur_wr ? 0 : RD_LAT);
                free_at   = cur_a + 1;
            end else begin
                free_at = cyc + 1;
            end
        end
    endtask

    task automatic model_expect();
        x_rd = 1'b0; x_wr = 1'b0; x_busy = 1'b0;
        x_ack[0] = 1'b0; x_ack[1] = 1'b0;
        if (act) begin
            if (cyc == cur_g + 1) begin
                e_owner = cur_m;
                e_addr  = cur_addr;
                e_data  = cur_wdata;
                x_wr    = cur_wr;
                x_rd    = ~cur_wr;
                if (cur_wr) ref_mem[cur_addr[9:0]] = cur_wdata;
            end
            x_busy = (cyc > cur_g) && (cyc <= cur_a);
            if (cyc == cur_a) begin
                x_ack[cur_m] = 1'b1;
                if (!cur_wr) e_rdata[cur_m] = ref_mem[cur_addr[9:0]];
                lw  = cur_m;
                act = 1'b0;
            end
        end
    endtask

    // Read word appears exactly RD_LAT cycles after the strobe; junk otherwise.
    task automatic mem_standin();
        bus.i_mem_data = 16'($urandom);
        while (pend_due.size() != 0 && pend_due[0] < cyc) begin
            void'(pend_due.pop_front());
            void'(pend_addr.pop_front());
        end
        if (pend_due.size() != 0 && pend_due[0] == cyc) begin
            bus.i_mem_data = mem[pend_addr[0][9:0]];
            void'(pend_due.pop_front());
            void'(pend_addr.pop_front());
        end
        if (bus.o_mem_rd === 1'b1) begin
            pend_due.push_back(cyc + RD_LAT);
            pend_addr.push_back(bus.o_mem_address);
        end
        if (bus.o_mem_wr === 1'b1) mem[bus.o_mem_address[9:0]] = bus.o_mem_data;
    endtask

    task automatic tick();
        @(posedge clk);
        model_sample();
        #1;
        cyc++;
        model_expect();
        mem_standin();
    endtask

    task automatic new_req(input int m);
        req[m]   = 1'b1;
        wr[m]    = 1'($urandom_range(1));
        addr[m]  = 16'($urandom_range(31));
        wdata[m] = 16'($urandom);
    endtask

    task automatic rand_drive();
        logic ackv [2];
        ackv[0] = bus.o_m0_ack;
        ackv[1] = bus.o_m1_ack;
        for (int m = 0; m < 2; m++) begin
            if (req[m]) begin
                if (ackv[m]) begin
                    if ($urandom_range(1) == 0) req[m] = 1'b0;
                    else                        new_req(m);
                end else if ($urandom_range(59) == 0) begin
                    req[m] = 1'b0;
                end
            end else if ($urandom_range(3) == 0) begin
                new_req(m);
            end
        end
        rst = ($urandom_range(299) == 0);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk1 ("mem_rd",     bus.o_mem_rd, x_rd);
            chk1 ("mem_wr",     bus.o_mem_wr, x_wr);
            chk1 ("rd_wr_excl", bus.o_mem_rd & bus.o_mem_wr, 1'b0);
            chk1 ("ack0",       bus.o_m0_ack, x_ack[0]);
            chk1 ("ack1",       bus.o_m1_ack, x_ack[1]);
            chk1 ("busy",       bus.o_busy, x_busy);
            chk1 ("owner",      bus.o_owner, e_owner);
            chk16("mem_addr",   bus.o_mem_address, e_addr);
            chk16("mem_data",   bus.o_mem_data, e_data);
            chk16("rdata0",     bus.o_m0_rdata, e_rdata[0]);
            chk16("rdata1",     bus.o_m1_rdata, e_rdata[1]);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit exp_o;
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0; wr[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
            e_rdata[i] = '0; x_ack[i] = 1'b0;
        end
        for (int i = 0; i < 1024; i++) begin
            mem[i]     = 16'(i * 37 + 5);
            ref_mem[i] = mem[i];
        end
        bus.i_mem_data = '0;
        act = 1'b0; lw = 1'b1; free_at = 0;
        e_owner = 1'b0; e_addr = '0; e_data = '0;

        // reset state
        rst = 1'b1;
        tick();
        chk_en = 1'b1;
        @(negedge clk);
        chk1 ("rst_busy",  bus.o_busy, 1'b0);
        chk1 ("rst_owner", bus.o_owner, 1'b0);
        chk1 ("rst_rd",    bus.o_mem_rd, 1'b0);
        chk1 ("rst_ack0",  bus.o_m0_ack, 1'b0);
        chk16("rst_addr",  bus.o_mem_address, 16'h0000);
        tick();
        tick();
        rst = 1'b0;

        // m0 write 0x0010 <= 0xBEEF
        req[0] = 1'b1; wr[0] = 1'b1; addr[0] = 16'h0010; wdata[0] = 16'hBEEF;
        tick(); @(negedge clk);
        chk1 ("t1_wr",    bus.o_mem_wr, 1'b1);
        chk1 ("t1_rd",    bus.o_mem_rd, 1'b0);
        chk16("t1_addr",  bus.o_mem_address, 16'h0010);
        chk16("t1_data",  bus.o_mem_data, 16'hBEEF);
        chk1 ("t1_early", bus.o_m0_ack, 1'b0);
        tick(); @(negedge clk);
        chk1 ("t1_ack0",  bus.o_m0_ack, 1'b1);
        chk1 ("t1_ack1",  bus.o_m1_ack, 1'b0);
        req[0] = 1'b0;
        tick();

        // m1 read 0x0010, ack at strobe + 1 + RD_LAT
        req[1] = 1'b1; wr[1] = 1'b0; addr[1] = 16'h0010; wdata[1] = 16'h5A5A;
        tick(); @(negedge clk);
        chk1 ("t2_rd",    bus.o_mem_rd, 1'b1);
        chk1 ("t2_wr",    bus.o_mem_wr, 1'b0);
        chk1 ("t2_owner", bus.o_owner, 1'b1);
        for (int k = 0; k < RD_LAT; k++) begin
            tick(); @(negedge clk);
            chk1("t2_early", bus.o_m1_ack, 1'b0);
        end
        tick(); @(negedge clk);
        chk1 ("t2_ack1",   bus.o_m1_ack, 1'b1);
        chk1 ("t2_ack0",   bus.o_m0_ack, 1'b0);
        chk16("t2_rdata1", bus.o_m1_rdata, 16'hBEEF);
        chk16("t2_rdata0", bus.o_m0_rdata, 16'h0000);
        req[1] = 1'b0;
        req[0] = 1'b1; wr[0] = 1'b0; addr[0] = 16'h0010; wdata[0] = 16'h0000;

        // m0 read raised in the ack cycle: next strobe two cycles after ack
        tick(); @(negedge clk);
        chk1 ("t4_gap_rd",   bus.o_mem_rd, 1'b0);
        chk1 ("t4_gap_busy", bus.o_busy, 1'b0);
        tick(); @(negedge clk);
        chk1 ("t4_rd",    bus.o_mem_rd, 1'b1);
        chk1 ("t4_owner", bus.o_owner, 1'b0);
        for (int k = 0; k < RD_LAT; k++) begin
            tick(); @(negedge clk);
            chk1("t4_early", bus.o_m0_ack, 1'b0);
        end
        tick(); @(negedge clk);
        chk1 ("t4_ack0",   bus.o_m0_ack, 1'b1);
        chk16("t4_rdata0", bus.o_m0_rdata, 16'hBEEF);
        chk16("t4_rdata1", bus.o_m1_rdata, 16'hBEEF);
        req[0] = 1'b0;
        tick();

        // reset while m1 read is waiting for data
        req[1] = 1'b1; wr[1] = 1'b0; addr[1] = 16'h0020;
        tick();
        tick();
        rst = 1'b1;
        tick(); @(negedge clk);
        rst = 1'b0;
        chk1 ("t5_busy", bus.o_busy, 1'b0);
        chk1 ("t5_rd",   bus.o_mem_rd, 1'b0);
        chk1 ("t5_wr",   bus.o_mem_wr, 1'b0);
        chk1 ("t5_ack0", bus.o_m0_ack, 1'b0);
        chk1 ("t5_ack1", bus.o_m1_ack, 1'b0);
        req[0] = 1'b1; wr[0] = 1'b1; addr[0] = 16'h0021; wdata[0] = 16'hCAFE;
        tick(); @(negedge clk);
        chk1 ("t5_owner", bus.o_owner, 1'b0);
        chk1 ("t5_wr2",   bus.o_mem_wr, 1'b1);
        tick(); @(negedge clk);
        chk1 ("t5_ack0b", bus.o_m0_ack, 1'b1);
        req[0] = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // both masters hold write requests continuously
        req[0] = 1'b1; wr[0] = 1'b1; addr[0] = 16'h0030; wdata[0] = 16'h1111;
        req[1] = 1'b1; wr[1] = 1'b1; addr[1] = 16'h0031; wdata[1] = 16'h2222;
        for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            exp_o = 1'b0;
`else
            exp_o = (k % 2) == 1;
`endif
            tick(); @(negedge clk);
            chk1 ("t3_owner", bus.o_owner, exp_o);
            chk16("t3_addr",  bus.o_mem_address, exp_o ? 16'h0031 : 16'h0030);
            tick(); @(negedge clk);
            chk1 ("t3_ack",   exp_o ? bus.o_m1_ack : bus.o_m0_ack, 1'b1);
            tick();
        end
        req[0] = 1'b0;
        req[1] = 1'b0;
        tick();

        // random traffic with occasional resets
        for (int n = 0; n < 4000; n++) begin
            tick();
            rand_drive();
        end
        rst = 1'b0;
        req[0] = 1'b0;
        req[1] = 1'b0;
        repeat (20) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
